// File: rtl/kyber_pkg.sv
// Shared Kyber constants, the coefficient type and an exact mod-Q reduction.
package kyber_pkg;

  localparam int N = 256;
  localparam int NPAIRS = N / 2;

  typedef logic [15:0] coeff_t;

  localparam coeff_t Q = 16'd3329;

  // Barrett constant floor(2^34 / Q); the estimate is at most one short, so one subtract suffices.
  localparam logic [22:0] BARRETT_M = 23'((64'd1 << 34) / 64'(Q));

  function automatic coeff_t mod_q(input logic [33:0] x);
    logic [22:0] qest;
    logic [35:0] r;
    qest = 23'((57'(x) * 57'(BARRETT_M)) >> 34);
    r = 36'(x) - 36'(qest) * 36'(Q);
    if (r >= 36'(Q)) r = r - 36'(Q);
    return 16'(r);
  endfunction

endpackage

// File: rtl/base_case_mul.sv
// One lane of the degree-1 base-case product modulo X^2 - gamma.
// Stage 1 registers operands and a1*b1; stage 2 is combinational and feeds the h registers.
module base_case_mul
  import kyber_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  coeff_t i_a0,
  input  coeff_t i_a1,
  input  coeff_t i_b0,
  input  coeff_t i_b1,
  input  coeff_t i_gamma,
  output coeff_t o_h_even,
  output coeff_t o_h_odd
);

  coeff_t      r_a0, r_a1, r_b0, r_b1, r_gamma;
  logic [31:0] r_p11;
  coeff_t      w_r11;
  logic [33:0] w_sum_even;
  logic [33:0] w_sum_odd;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a0    <= '0;
      r_a1    <= '0;
      r_b0    <= '0;
      r_b1    <= '0;
      r_gamma <= '0;
      r_p11   <= '0;
    end else begin
      r_a0    <= i_a0;
      r_a1    <= i_a1;
      r_b0    <= i_b0;
      r_b1    <= i_b1;
      r_gamma <= i_gamma;
      r_p11   <= 32'(i_a1) * 32'(i_b1);
    end
  end

  // a1*b1 is reduced first so its product with gamma stays well inside 34 bits.
  assign w_r11      = mod_q(34'(r_p11));
  assign w_sum_even = 34'(r_a0) * 34'(r_b0) + 34'(w_r11) * 34'(r_gamma);
  assign w_sum_odd  = 34'(r_a0) * 34'(r_b1) + 34'(r_a1) * 34'(r_b0);
  assign o_h_even   = mod_q(w_sum_even);
  assign o_h_odd    = mod_q(w_sum_odd);

endmodule

// File: rtl/multiply_ntts.sv
// Free-running NTT-domain pointwise multiplier: LANES pairs per cycle, sweeping all 128 pairs forever.
// Holds the sweep counter, gamma selection, operand muxing and the registered h array.
module multiply_ntts
  import kyber_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  coeff_t f     [N],
  input  coeff_t g     [N],
  input  coeff_t zetas [NPAIRS],
  output coeff_t h     [N]
);

  localparam int SWEEP = NPAIRS / LANES;
  localparam int CNT_W = (SWEEP > 1) ? $clog2(SWEEP) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_s1_cnt;
  logic             r_s1_valid;
  coeff_t           r_h [N];

  coeff_t     w_h_even  [LANES];
  coeff_t     w_h_odd   [LANES];
  logic [6:0] w_wr_pair [LANES];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [6:0] w_pair;
    coeff_t     w_zeta;
    coeff_t     w_gamma;

    assign w_pair  = 7'(int'(r_cnt) * LANES + gi);
    assign w_zeta  = zetas[{1'b0, w_pair[6:1]}];
    // Odd pairs use -zeta mod Q, keeping zero canonical.
    assign w_gamma = !w_pair[0] ? w_zeta : ((w_zeta == '0) ? '0 : Q - w_zeta);
    assign w_wr_pair[gi] = 7'(int'(r_s1_cnt) * LANES + gi);

    base_case_mul u_lane (
      .clk      (clk),
      .reset    (reset),
      .i_a0     (f[{w_pair, 1'b0}]),
      .i_a1     (f[{w_pair, 1'b1}]),
      .i_b0     (g[{w_pair, 1'b0}]),
      .i_b1     (g[{w_pair, 1'b1}]),
      .i_gamma  (w_gamma),
      .o_h_even (w_h_even[gi]),
      .o_h_odd  (w_h_odd[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_s1_cnt   <= '0;
      r_s1_valid <= 1'b0;
      for (int k = 0; k < N; k++) r_h[k] <= '0;
    end else begin
      r_cnt      <= (r_cnt == CNT_W'(SWEEP - 1)) ? '0 : r_cnt + 1'b1;
      r_s1_cnt   <= r_cnt;
      r_s1_valid <= 1'b1;
      if (r_s1_valid) begin
        for (int l = 0; l < LANES; l++) begin
          r_h[{w_wr_pair[l], 1'b0}] <= w_h_even[l];
          r_h[{w_wr_pair[l], 1'b1}] <= w_h_odd[l];
        end
      end
    end
  end

  assign h = r_h;

endmodule

// File: tb/tb_multiply_ntts.sv
// Self-checking bench for multiply_ntts against a plain-arithmetic MultiplyNTTs model.
module tb_multiply_ntts;

  localparam int LANES = 4;
  localparam int QV = 3329;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] f     [256];
  logic [15:0] g     [256];
  logic [15:0] zetas [128];
  logic [15:0] h     [256];
  int          exp_h [256];
  int          n_checks = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  multiply_ntts #(.LANES(LANES)) dut (
    .clk   (clk),
    .reset (reset),
    .f     (f),
    .g     (g),
    .zetas (zetas),
    .h     (h)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rand_coeff();
    int unsigned sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return 16'd0;
    if (sel == 1) return 16'd3328;
    return 16'($urandom_range(0, 3328));
  endfunction

  task automatic fill_random();
    for (int k = 0; k < 256; k++) begin
      f[k] = rand_coeff();
      g[k] = rand_coeff();
    end
    for (int k = 0; k < 128; k++) zetas[k] = rand_coeff();
  endtask

  // Reference: each pair is (a0 + a1 X)(b0 + b1 X) mod (X^2 - gamma), gamma alternating +/- zeta.
  task automatic compute_model();
    longint a0, a1, b0, b1, z, gam;
    for (int i = 0; i < 128; i++) begin
      z   = longint'(zetas[i / 2]);
      gam = (i % 2 == 0) ? z : ((QV - z) % QV);
      a0  = longint'(f[2 * i]);
      a1  = longint'(f[2 * i + 1]);
      b0  = longint'(g[2 * i]);
      b1  = longint'(g[2 * i + 1]);
      exp_h[2 * i]     = int'((a0 * b0 + ((a1 * b1) % QV) * gam) % QV);
      exp_h[2 * i + 1] = int'((a0 * b1 + a1 * b0) % QV);
    end
  endtask

  task automatic test_reset();
    int expv;
    fill_random();
    compute_model();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int k = 0; k < 256; k++) begin
        n_checks++;
        if (h[k] !== 16'd0) begin
          n_bad++;
          $display("FAIL reset_hold cyc=%0d h[%0d] got=%0d want=0", c, k, h[k]);
        end
      end
    end
    reset = 1'b0;
    // Pair group c retires on the (c+2)th edge after release; later groups must still read zero.
    for (int e = 1; e <= 34; e++) begin
      tick();
      for (int k = 0; k < 256; k++) begin
        expv = ((k / 2) / LANES <= e - 2) ? exp_h[k] : 0;
        n_checks++;
        if (h[k] !== 16'(expv)) begin
          n_bad++;
          $display("FAIL reset_release edge=%0d h[%0d] got=%0d want=%0d", e, k, h[k], expv);
        end
      end
    end
    $display("reset test: 3 reset cycles then 34 release cycles checked");
  endtask

  task automatic test_directed();
    int fixed_h [4][4];
    int n_fixed;
    fixed_h = '{'{5, 7, 0, 0}, '{17, 0, 3312, 0}, '{18, 2, 0, 0}, '{496, 394, 0, 0}};
    for (int tc = 0; tc < 4; tc++) begin
      for (int k = 0; k < 128; k++) zetas[k] = rand_coeff();
      zetas[0] = 16'd17;
      for (int k = 0; k < 256; k++) begin
        f[k] = (tc == 3) ? rand_coeff() : 16'd0;
        g[k] = (tc == 3) ? rand_coeff() : 16'd0;
      end
      n_fixed = 4;
      case (tc)
        0: begin f[0] = 16'd1; g[0] = 16'd5; g[1] = 16'd7; end
        1: begin f[1] = 16'd1; g[1] = 16'd1; f[3] = 16'd1; g[3] = 16'd1; end
        2: begin f[0] = 16'd3328; f[1] = 16'd3328; g[0] = 16'd3328; g[1] = 16'd3328; end
        default: begin
          f[0] = 16'd245; f[1] = 16'd1023; g[0] = 16'd1864; g[1] = 16'd1825;
          n_fixed = 2;
        end
      endcase
      compute_model();
      repeat (34) tick();
      for (int k = 0; k < n_fixed; k++) begin
        n_checks++;
        if (h[k] !== 16'(fixed_h[tc][k])) begin
          n_bad++;
          $display("FAIL directed case=%0d h[%0d] got=%0d want=%0d", tc, k, h[k], fixed_h[tc][k]);
        end
      end
      for (int k = 0; k < 256; k++) begin
        n_checks++;
        if (h[k] !== 16'(exp_h[k])) begin
          n_bad++;
          $display("FAIL directed_full case=%0d h[%0d] got=%0d want=%0d", tc, k, h[k], exp_h[k]);
        end
      end
      $display("directed case %0d: h[0..3]=%0d %0d %0d %0d", tc, h[0], h[1], h[2], h[3]);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      fill_random();
      if (it == 0) for (int k = 0; k < 64; k++) zetas[k] = 16'd0;
      compute_model();
      repeat (34) tick();
      for (int k = 0; k < 256; k++) begin
        n_checks++;
        if (h[k] !== 16'(exp_h[k])) begin
          n_bad++;
          $display("FAIL random it=%0d h[%0d] got=%0d want=%0d", it, k, h[k], exp_h[k]);
        end
      end
      $display("random vector %0d: h[0]=%0d h[255]=%0d", it, h[0], h[255]);
    end
  endtask

  task automatic test_midsweep_reset();
    int expv;
    fill_random();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    for (int k = 0; k < 256; k++) begin
      n_checks++;
      if (h[k] !== 16'd0) begin
        n_bad++;
        $display("FAIL midsweep_clear h[%0d] got=%0d want=0", k, h[k]);
      end
    end
    for (int k = 0; k < 256; k++) f[k] = rand_coeff();
    compute_model();
    reset = 1'b0;
    for (int e = 1; e <= 34; e++) begin
      tick();
      for (int k = 0; k < 256; k++) begin
        expv = ((k / 2) / LANES <= e - 2) ? exp_h[k] : 0;
        n_checks++;
        if (h[k] !== 16'(expv)) begin
          n_bad++;
          $display("FAIL midsweep_restart edge=%0d h[%0d] got=%0d want=%0d", e, k, h[k], expv);
        end
      end
    end
    $display("mid-sweep reset: cleared and restarted from pair 0");
  endtask

  initial begin
    for (int k = 0; k < 256; k++) begin
      f[k] = 16'd0;
      g[k] = 16'd0;
    end
    for (int k = 0; k < 128; k++) zetas[k] = 16'd0;
    test_reset();
    test_directed();
    test_random();
    test_midsweep_reset();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
